// File: rtl/mem_stage_pipe.sv
// Data-memory stage between the E/M and M/W registers: sized loads/stores with extension,
// address exception detection and an optional multi-cycle access guarded by a stall handshake.
module mem_stage_pipe #(
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_wreg,
  input  logic        in_regwrite,
  input  logic [31:0] in_pc,
  output logic        in_ready,
  output logic        stall,
  output logic        wb_valid,
  output logic        wb_regwrite,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic [31:0] wb_pc,
  output logic        exc,
  output logic [1:0]  exc_code
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH_L  = 32'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(MEM_LATENCY - 1);
  localparam bit          MULTI    = (MEM_LATENCY > 1);

  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LB  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt_p0, cnt_nxt;

  logic [3:0]  op_p0;
  logic [31:0] addr_p0, wdata_p0, pc_p0;
  logic [4:0]  wreg_p0;
  logic        regwrite_p0;

  logic        busy;
  logic [3:0]  req_op;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic [4:0]  req_wreg;
  logic        req_regwrite;

  logic [31:0] offset;
  logic [29:0] word_idx;
  logic [1:0]  lane;
  logic        is_load, is_store, is_mem;
  logic        out_of_range, misaligned, bad;
  logic        fire_now, start, done, complete, commit;
  logic [31:0] rd_word, merged;
  logic [31:0] res_data;
  logic        res_rw;
  logic [1:0]  res_code;

  // Zero at start of simulation; deliberately untouched by reset.
  logic [31:0] mem [DEPTH_WORDS] = '{default: 32'h0};

  function automatic logic [31:0] load_extract(input logic [3:0]  op,
                                               input logic [1:0]  ln,
                                               input logic [31:0] word);
    logic [7:0]         bval;
    logic [15:0]        hval;
    logic signed [31:0] sext;
    case (ln)
      2'd0:    bval = word[7:0];
      2'd1:    bval = word[15:8];
      2'd2:    bval = word[23:16];
      default: bval = word[31:24];
    endcase
    hval = ln[1] ? word[31:16] : word[15:0];
    sext = signed'(word);
    case (op)
      OP_LH:   sext = 32'(signed'(hval));
      OP_LHU:  sext = signed'({16'h0000, hval});
      OP_LB:   sext = 32'(signed'(bval));
      OP_LBU:  sext = signed'({24'h00_0000, bval});
      default: sext = signed'(word);
    endcase
    return unsigned'(sext);
  endfunction

  function automatic logic [31:0] store_merge(input logic [3:0]  op,
                                              input logic [1:0]  ln,
                                              input logic [31:0] word,
                                              input logic [31:0] wdata);
    logic [31:0] m;
    m = word;
    case (op)
      OP_SW: m = wdata;
      OP_SH: begin
        if (ln[1]) m[31:16] = wdata[15:0];
        else       m[15:0]  = wdata[15:0];
      end
      OP_SB: begin
        case (ln)
          2'd0:    m[7:0]   = wdata[7:0];
          2'd1:    m[15:8]  = wdata[7:0];
          2'd2:    m[23:16] = wdata[7:0];
          default: m[31:24] = wdata[7:0];
        endcase
      end
      default: m = word;
    endcase
    return m;
  endfunction

  // While busy the latched request drives everything; fresh inputs are ignored.
  always_comb begin
    busy = (state == BUSY);
    if (busy) begin
      req_op       = op_p0;
      req_addr     = addr_p0;
      req_wdata    = wdata_p0;
      req_wreg     = wreg_p0;
      req_regwrite = regwrite_p0;
      req_pc       = pc_p0;
    end else begin
      req_op       = in_op;
      req_addr     = in_addr;
      req_wdata    = in_wdata;
      req_wreg     = in_wreg;
      req_regwrite = in_regwrite;
      req_pc       = in_pc;
    end
  end

  assign offset       = req_addr - BASE_ADDR;
  assign word_idx     = offset[31:2];
  assign lane         = offset[1:0];
  assign is_load      = (req_op >= OP_LW) && (req_op <= OP_LBU);
  assign is_store     = (req_op >= OP_SW) && (req_op <= OP_SB);
  assign is_mem       = is_load || is_store;
  assign out_of_range = (req_addr < BASE_ADDR) || ({2'b00, word_idx} >= DEPTH_L);

  always_comb begin
    misaligned = 1'b0;
    case (req_op)
      OP_LW, OP_SW:         misaligned = |lane;
      OP_LH, OP_LHU, OP_SH: misaligned = lane[0];
      default:              misaligned = 1'b0;
    endcase
  end

  assign bad     = is_mem && (out_of_range || misaligned);
  assign rd_word = mem[word_idx[IDX_W-1:0]];
  assign merged  = store_merge(req_op, lane, rd_word, req_wdata);

  // Exceptions and NONE never wait for memory, whatever the latency.
  assign fire_now = !busy && in_valid && (!is_mem || bad || !MULTI);
  assign start    = !busy && in_valid && is_mem && !bad && MULTI;
  assign done     = busy && (cnt_p0 == 4'd1);
  assign complete = fire_now || done;
  assign commit   = complete && is_store && !bad && reset;

  assign in_ready = !busy;
  assign stall    = in_valid && busy;

  always_comb begin
    res_data = req_addr;
    res_rw   = 1'b0;
    res_code = 2'b00;
    if (!is_mem) begin
      res_rw = req_regwrite;
    end else if (bad) begin
      res_code = is_load ? 2'b01 : 2'b10;
    end else if (is_load) begin
      res_data = load_extract(req_op, lane, rd_word);
      res_rw   = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_p0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_INIT;
        end
      end
      BUSY: begin
        cnt_nxt = cnt_p0 - 4'd1;
        if (cnt_p0 == 4'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- request latch / access counter ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt_p0      <= 4'd0;
      op_p0       <= 4'd0;
      addr_p0     <= 32'h0;
      wdata_p0    <= 32'h0;
      wreg_p0     <= 5'd0;
      regwrite_p0 <= 1'b0;
      pc_p0       <= 32'h0;
    end else begin
      state  <= state_nxt;
      cnt_p0 <= cnt_nxt;
      if (start) begin
        op_p0       <= in_op;
        addr_p0     <= in_addr;
        wdata_p0    <= in_wdata;
        wreg_p0     <= in_wreg;
        regwrite_p0 <= in_regwrite;
        pc_p0       <= in_pc;
      end
    end
  end

  // ---- M/W register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_reg      <= 5'd0;
      wb_data     <= 32'h0;
      wb_pc       <= 32'h0;
      exc         <= 1'b0;
      exc_code    <= 2'b00;
    end else begin
      wb_valid    <= complete;
      wb_regwrite <= 1'b0;
      if (complete) begin
        wb_regwrite <= res_rw;
        wb_reg      <= req_wreg;
        wb_data     <= res_data;
        wb_pc       <= req_pc;
        exc         <= bad;
        exc_code    <= res_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      mem[word_idx[IDX_W-1:0]] <= merged;
`ifndef SYNTHESIS
      $display("@%h: *%h <= %h", req_pc, {req_addr[31:2], 2'b00}, merged);
`endif
    end
  end

endmodule
